bf16_mul_arbiter: RTL and testbench
===================================

Name: bf16_mul_arbiter

Overview:
Round-robin scheduler that shares one combinational BF16 multiplier between NREQ requesters. It accepts operand pairs over valid/ready, drives the shared multiplier's operand inputs and waits a programmable settle time. It then captures the product and returns it to the winning requester over a valid/ready response channel. Signed-zero operands bypass the multiplier. The block sits between the requester datapaths and the `mul` instance, whose 16-bit `sum` output feeds `mul_p`.

Parameters:
- NREQ, 2, number of requesters (2..8).
- MUL_LAT, 1, cycles operands are held on mul_a/mul_b before mul_p is sampled (1..15).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester operand-valid.
- req_a  in  16*NREQ  BF16 operand A; requester i occupies bits [16i+15:16i].
- req_b  in  16*NREQ  BF16 operand B; same packing as req_a.
- req_ready  out  NREQ  one-hot accept for the granted requester.
- mul_a  out  16  operand A to the shared multiplier.
- mul_b  out  16  operand B to the shared multiplier.
- mul_p  in  16  BF16 product from the shared multiplier.
- rsp_valid  out  NREQ  one-hot result-valid to the owning requester.
- rsp_data  out  16  BF16 result, common to all requesters.
- rsp_ready  in  NREQ  per-requester result-accept.
- busy  out  1  high in any state other than IDLE.
- ops_done  out  16  count of completed responses; wraps from 0xFFFF to 0.

Behaviour:
- Reset values (synchronous, rst=1 at a clk edge):
  - state = IDLE, rr_ptr = 0, all registered outputs = 0.
  - mul_a = mul_b = 0, rsp_data = 0, ops_done = 0, busy = 0.
  - req_ready = 0 and rsp_valid = 0 while rst is high.
- Reset mid-operation drops the in-flight transaction; no response is ever produced for it.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant = first i with req_valid[i]=1, searching i = rr_ptr, rr_ptr+1, … modulo NREQ.
  - req_ready is combinational: it is one-hot at grant in IDLE only, and all-zero otherwise.
  - Accept occurs at an edge where req_valid[g] & req_ready[g] (call it cycle T). On accept:
    - owner <= g; rr_ptr <= (g+1) mod NREQ.
    - mul_a <= req_a[g]; mul_b <= req_b[g].
  - Zero bypass: if either operand has bits [14:0] == 0, then rsp_data <= {a[15]^b[15], 15'h0} and the FSM goes directly to RESP.
  - Otherwise cnt <= MUL_LAT-1 and the FSM goes to ISSUE.
- ISSUE:
  - mul_a/mul_b are held stable.
  - When cnt==0: rsp_data <= mul_p and the FSM goes to RESP.
  - Otherwise cnt decrements.
- RESP:
  - rsp_valid[owner] = 1, and rsp_data is held stable.
  - On rsp_ready[owner]: ops_done increments and the FSM goes to IDLE.
  - rsp_ready on non-owner lines is ignored.
  - rsp_valid stays asserted until accepted; the producer never withdraws it.
- Latency and throughput:
  - Accept at edge T: rsp_valid rises after edge T+MUL_LAT+1 for a normal operation, and after edge T+1 for a bypass.
  - Minimum issue interval: MUL_LAT+2 cycles normal, 2 cycles bypass.
- mul_a/mul_b retain the last operands after completion; no combinational path exists from req_* to mul_*.
- Requests arriving during ISSUE/RESP wait and are not dropped. Requesters hold req_valid and operands stable until ready.
- Fairness: with all NREQ requesters continuously valid, grants rotate 0,1,…,NREQ-1,0…, with no requester granted twice within NREQ grants.
- Width rules:
  - cnt is 4 bits; rr_ptr is clog2(NREQ) bits and wraps modulo NREQ; ops_done is 16 bits and wraps.
  - No rounding or normalisation happens in this block; mul_p passes through unmodified.

Test Plan:
- Single op, MUL_LAT=1: req 0 sends a=0x3F80, b=0x4000, with mul_p driven by the team's `mul` model. Required: req_ready[0] is high in the accept cycle; rsp_valid[0] rises 2 cycles after accept; rsp_data equals the model's output for those operands; ops_done=1.
- Zero bypass: req 1 sends a=0x8000, b=0x4040. Required: rsp_valid[1] one cycle after accept; rsp_data=0x8000; mul_p is not sampled (drive it to 0xFFFF to prove this).
- Round-robin: both requesters are held valid for 6 ops with rsp_ready tied high. Required grant order 0,1,0,1,0,1; every grant is 3 cycles apart; ops_done=6.
- Backpressure: rsp_ready[0]=0 for 5 cycles during RESP while req 1 is valid. Required: rsp_valid[0] and rsp_data stay stable; req_ready[1] stays 0 until rsp_ready[0] is accepted; req 1 is then granted in the next IDLE cycle.
- Reset mid-op: assert rst during ISSUE with MUL_LAT=4. Required: the next cycle shows busy=0, rsp_valid=0, mul_a=mul_b=0, rr_ptr=0; a following request from req 1 completes normally.
- Counter wrap: preload the bench to 65535 completions. Required: ops_done reads 0xFFFF, then 0x0000 after the next response.

Source files
------------

// File: rtl/bf16_mul_arbiter.sv
// Round-robin arbiter sharing one combinational BF16 multiplier among NREQ requesters.
// Signed-zero operands bypass the multiplier; results return over a valid/ready channel.
module bf16_mul_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned MUL_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_p,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  input  logic [NREQ-1:0]      rsp_ready,
  output logic                 busy,
  output logic [15:0]          ops_done
);

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = $clog2(NREQ);
  localparam int unsigned SW = PW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   mul_a_q, mul_a_d;
  logic [DW-1:0]   mul_b_q, mul_b_d;
  logic [DW-1:0]   rsp_data_q, rsp_data_d;
  logic [DW-1:0]   ops_done_q, ops_done_d;

  logic [DW-1:0]   op_a [NREQ];
  logic [DW-1:0]   op_b [NREQ];
  logic            gnt_found;
  logic [PW-1:0]   gnt_idx;
  logic [SW-1:0]   scan_sum;
  logic [PW-1:0]   scan_idx;
  logic [DW-1:0]   gnt_a, gnt_b;
  logic            gnt_zero;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign op_a[i] = req_a[DW*i +: DW];
    assign op_b[i] = req_b[DW*i +: DW];
  end

  // Rotating priority search starting at rr_ptr
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      scan_sum = SW'(rr_ptr_q) + SW'(k);
      scan_idx = (scan_sum >= SW'(NREQ)) ? PW'(scan_sum - SW'(NREQ)) : PW'(scan_sum);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  assign gnt_a    = op_a[gnt_idx];
  assign gnt_b    = op_b[gnt_idx];
  assign gnt_zero = (gnt_a[14:0] == 15'h0) || (gnt_b[14:0] == 15'h0);

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    rsp_data_d = rsp_data_q;
    ops_done_d = ops_done_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          owner_d  = gnt_idx;
          rr_ptr_d = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
          mul_a_d  = gnt_a;
          mul_b_d  = gnt_b;
          if (gnt_zero) begin
            rsp_data_d = {gnt_a[15] ^ gnt_b[15], 15'h0};
            state_d    = RESP;
          end else begin
            cnt_d   = CW'(MUL_LAT - 1);
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cnt_q == '0) begin
          rsp_data_d = mul_p;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready[owner_q]) begin
          ops_done_d = ops_done_q + DW'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      rsp_data_q <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      rsp_data_q <= rsp_data_d;
      ops_done_q <= ops_done_d;
    end
  end

  // Handshake strobes decode from state; both are forced low while in reset
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    if (!rst && state_q == IDLE && gnt_found) req_ready[gnt_idx] = 1'b1;
    if (!rst && state_q == RESP) rsp_valid[owner_q] = 1'b1;
  end

  assign mul_a    = mul_a_q;
  assign mul_b    = mul_b_q;
  assign rsp_data = rsp_data_q;
  assign ops_done = ops_done_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_bf16_mul_arbiter.sv
// Bench for bf16_mul_arbiter: directed protocol steps plus a randomized run against a
// transaction-level model (round-robin pick, fixed latencies, BF16 product model).
module tb_bf16_mul_arbiter;

  localparam int unsigned LAT_A = 1;
  localparam int unsigned LAT_B = 4;

  logic        clk;
  // instance A: MUL_LAT=1
  logic        rst;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [31:0] req_a, req_b;
  logic [15:0] mul_a, mul_b, mul_p, rsp_data, ops_done;
  logic        busy;
  logic        mul_force;
  // instance B: MUL_LAT=4
  logic        rst_4;
  logic [1:0]  req_valid_4, req_ready_4, rsp_valid_4, rsp_ready_4;
  logic [31:0] req_a_4, req_b_4;
  logic [15:0] mul_a_4, mul_b_4, mul_p_4, rsp_data_4, ops_done_4;
  logic        busy_4;

  int          checks;
  int          failures;

  // Behavioural BF16 multiplier (truncating, denormals flushed to signed zero)
  function automatic logic [15:0] bf16_mul(input logic [15:0] a, input logic [15:0] b);
    logic        s;
    logic [15:0] prod;
    int          e;
    logic [6:0]  frac;
    s = a[15] ^ b[15];
    if (a[14:7] == 8'h0 || b[14:7] == 8'h0) return {s, 15'h0};
    prod = {8'h0, 1'b1, a[6:0]} * {8'h0, 1'b1, b[6:0]};
    e    = int'(a[14:7]) + int'(b[14:7]) - 127;
    if (prod[15]) begin
      frac = prod[14:8];
      e    = e + 1;
    end else begin
      frac = prod[13:7];
    end
    if (e <= 0) return {s, 15'h0};
    if (e >= 255) return {s, 8'hFF, 7'h0};
    return {s, 8'(e), frac};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [31:0] r;
    r = $urandom;
    if (r[1:0] == 2'd0) return {r[31], 15'h0};
    return {r[30], 8'(100 + int'(r[15:8]) % 50), r[22:16]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  assign mul_p   = mul_force ? 16'hFFFF : bf16_mul(mul_a, mul_b);
  assign mul_p_4 = bf16_mul(mul_a_4, mul_b_4);

  bf16_mul_arbiter #(.NREQ(2), .MUL_LAT(LAT_A)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy), .ops_done(ops_done)
  );

  bf16_mul_arbiter #(.NREQ(2), .MUL_LAT(LAT_B)) dut4 (
    .clk(clk), .rst(rst_4), .req_valid(req_valid_4), .req_a(req_a_4), .req_b(req_b_4),
    .req_ready(req_ready_4), .mul_a(mul_a_4), .mul_b(mul_b_4), .mul_p(mul_p_4),
    .rsp_valid(rsp_valid_4), .rsp_data(rsp_data_4), .rsp_ready(rsp_ready_4),
    .busy(busy_4), .ops_done(ops_done_4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // random-phase model state
  int          n_gnt;
  int          gnt_who [6];
  int          gnt_cyc [6];
  int          mptr, g, own, acc_c, lat, exp_ops;
  logic        in_fl, byp;
  logic [1:0]  drop, exp_v;
  logic [15:0] ea, eb, exp_d;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rst_4 = 1'b1; mul_force = 1'b0;
    req_valid = 2'b11; req_a = 32'h4000_3F80; req_b = 32'h4000_4000; rsp_ready = 2'b00;
    req_valid_4 = 2'b00; req_a_4 = '0; req_b_4 = '0; rsp_ready_4 = 2'b00;

    // reset state, with requests already pending
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_mul_b", 32'(mul_b), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_ops_done", 32'(ops_done), 32'h0);

    // single normal op from req 0
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 2'b01; req_a = 32'h0000_3F80; req_b = 32'h0000_4000;
    @(negedge clk);
    chk("single_accept", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_t1_valid", 32'(rsp_valid), 32'h0);
    chk("single_t1_busy", 32'(busy), 32'h1);
    chk("single_mul_a", 32'(mul_a), 32'h3F80);
    chk("single_mul_b", 32'(mul_b), 32'h4000);
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("single_t2_valid", 32'(rsp_valid), 32'h1);
    chk("single_data", 32'(rsp_data), 32'(bf16_mul(16'h3F80, 16'h4000)));
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("single_ops", 32'(ops_done), 32'd1);
    chk("single_idle", 32'(busy), 32'h0);

    // zero bypass from req 1; multiplier output poisoned
    @(posedge clk); #1;
    req_valid = 2'b10; req_a = 32'h8000_0000; req_b = 32'h4040_0000; mul_force = 1'b1;
    @(negedge clk);
    chk("byp_accept", 32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 2'b10;
    @(negedge clk);
    chk("byp_valid", 32'(rsp_valid), 32'h2);
    chk("byp_data", 32'(rsp_data), 32'h8000);
    @(posedge clk); #1;
    rsp_ready = 2'b00; mul_force = 1'b0;
    @(negedge clk);
    chk("byp_ops", 32'(ops_done), 32'd2);
    chk("byp_mul_a_kept", 32'(mul_a), 32'h8000);

    // round-robin with both requesters valid and responses always accepted
    @(posedge clk); #1;
    req_valid = 2'b11; req_a = 32'h4040_3FC0; req_b = 32'h4000_4080; rsp_ready = 2'b11;
    n_gnt = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (n_gnt < 6 && (req_valid & req_ready) != 2'b00) begin
        gnt_who[n_gnt] = req_ready[1] ? 1 : 0;
        gnt_cyc[n_gnt] = c;
        n_gnt++;
      end
      @(posedge clk); #1;
      if (n_gnt == 6) req_valid = 2'b00;
    end
    chk("rr_count", 32'(n_gnt), 32'd6);
    for (int i = 0; i < n_gnt; i++) begin
      chk("rr_order", 32'(gnt_who[i]), 32'(i % 2));
      if (i > 0) chk("rr_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
    end
    chk("rr_ops", 32'(ops_done), 32'd8);

    // backpressure on req 0 while req 1 waits; non-owner ready must be ignored
    req_valid = 2'b11; rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_accept0", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b10; rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_issue_ready", 32'(req_ready), 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'h1);
      chk("bp_hold_data", 32'(rsp_data), 32'(bf16_mul(16'h3FC0, 16'h4080)));
      chk("bp_hold_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b01;
    @(negedge clk);
    chk("bp_release_valid", 32'(rsp_valid), 32'h1);
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_next_grant", 32'(req_ready), 32'h2);
    chk("bp_ops", 32'(ops_done), 32'd9);
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 2'b10;
    @(negedge clk);
    chk("bp_r1_issue", 32'(rsp_valid), 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_r1_valid", 32'(rsp_valid), 32'h2);
    chk("bp_r1_data", 32'(rsp_data), 32'(bf16_mul(16'h4040, 16'h4000)));
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("bp_ops2", 32'(ops_done), 32'd10);

    // counter wrap: preload the completion count, then two bypass ops
    @(posedge clk); #1;
    dut.ops_done_q = 16'hFFFE;
    req_valid = 2'b01; req_a = 32'h0000_0000; req_b = 32'h0000_3F80;
    @(negedge clk);
    chk("wrap_accept", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 2'b01;
    @(negedge clk);
    chk("wrap_data0", 32'(rsp_data), 32'h0000);
    @(posedge clk); #1;
    rsp_ready = 2'b00; req_valid = 2'b10; req_a = 32'h4000_0000; req_b = 32'h8000_0000;
    @(negedge clk);
    chk("wrap_ffff", 32'(ops_done), 32'hFFFF);
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 2'b10;
    @(negedge clk);
    chk("wrap_data1", 32'(rsp_data), 32'h8000);
    @(posedge clk); #1;
    rsp_ready = 2'b00;
    @(negedge clk);
    chk("wrap_zero", 32'(ops_done), 32'h0000);

    // randomized traffic against the transaction model
    exp_ops = 0; mptr = 0; in_fl = 1'b0; drop = 2'b00;
    own = 0; acc_c = 0; lat = 0; exp_d = '0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      req_valid = req_valid & ~drop;
      drop = 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
          req_a[16*i +: 16] = rand_op();
          req_b[16*i +: 16] = rand_op();
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = 2'($urandom);
      @(negedge clk);
      chk("rnd_ops", 32'(ops_done), 32'(exp_ops));
      if (in_fl) begin
        exp_v = (c - acc_c >= lat) ? 2'(2'b01 << own) : 2'b00;
        chk("rnd_rsp_valid", 32'(rsp_valid), 32'(exp_v));
        chk("rnd_ready_busy", 32'(req_ready), 32'h0);
        if (exp_v != 2'b00) begin
          chk("rnd_rsp_data", 32'(rsp_data), 32'(exp_d));
          if (rsp_ready[own]) begin
            in_fl = 1'b0;
            exp_ops++;
          end
        end
      end else begin
        g = -1;
        for (int k = 0; k < 2; k++)
          if (g < 0 && req_valid[(mptr + k) % 2]) g = (mptr + k) % 2;
        chk("rnd_grant", 32'(req_ready), (g < 0) ? 32'h0 : 32'(1 << g));
        chk("rnd_idle_rsp", 32'(rsp_valid), 32'h0);
        if (g >= 0) begin
          ea    = req_a[16*g +: 16];
          eb    = req_b[16*g +: 16];
          byp   = (ea[14:0] == 15'h0) || (eb[14:0] == 15'h0);
          lat   = byp ? 1 : int'(LAT_A) + 1;
          exp_d = byp ? {ea[15] ^ eb[15], 15'h0} : bf16_mul(ea, eb);
          own   = g;
          acc_c = c;
          in_fl = 1'b1;
          mptr  = (g + 1) % 2;
          drop[g] = 1'b1;
        end
      end
    end
    @(posedge clk); #1;
    req_valid = 2'b00; rsp_ready = 2'b00;

    // reset mid-operation on the MUL_LAT=4 instance
    rst_4 = 1'b0; req_valid_4 = 2'b01; req_a_4 = 32'h0000_4040; req_b_4 = 32'h0000_4000;
    @(negedge clk);
    chk("rst4_accept", 32'(req_ready_4), 32'h1);
    @(posedge clk); #1;
    req_valid_4 = 2'b00;
    @(negedge clk);
    chk("rst4_in_issue", 32'(busy_4), 32'h1);
    @(posedge clk); #1;
    rst_4 = 1'b1;
    @(negedge clk);
    chk("rst4_ready_low", 32'(req_ready_4), 32'h0);
    @(posedge clk); #1;
    rst_4 = 1'b0;
    @(negedge clk);
    chk("rst4_busy", 32'(busy_4), 32'h0);
    chk("rst4_rsp_valid", 32'(rsp_valid_4), 32'h0);
    chk("rst4_mul_a", 32'(mul_a_4), 32'h0);
    chk("rst4_mul_b", 32'(mul_b_4), 32'h0);
    chk("rst4_rr_ptr", 32'(dut4.rr_ptr_q), 32'h0);
    rsp_ready_4 = 2'b11;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst4_no_rsp", 32'(rsp_valid_4), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready_4 = 2'b00; req_valid_4 = 2'b10; req_a_4 = 32'h3FC0_0000; req_b_4 = 32'h4080_0000;
    @(negedge clk);
    chk("rst4_r1_accept", 32'(req_ready_4), 32'h2);
    @(posedge clk); #1;
    req_valid_4 = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("rst4_r1_valid", 32'(rsp_valid_4), (k == 5) ? 32'h2 : 32'h0);
      if (k == 5) chk("rst4_r1_data", 32'(rsp_data_4), 32'(bf16_mul(16'h3FC0, 16'h4080)));
      @(posedge clk); #1;
      if (k == 4) rsp_ready_4 = 2'b10;
    end
    rsp_ready_4 = 2'b00;
    @(negedge clk);
    chk("rst4_ops", 32'(ops_done_4), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
